// File: rtl/video_types.sv
// Shared PPU types and default LCD timing geometry.
package video_types;

  typedef enum logic [1:0] {
    HBLANK = 2'd0,
    VBLANK = 2'd1,
    OAM    = 2'd2,
    XFER   = 2'd3
  } PpuMode;

  localparam int LCD_LINES     = 144;
  localparam int LCD_LINEWIDTH = 160;

  localparam int DEF_DOTS_PER_LINE   = 456;
  localparam int DEF_LINES_PER_FRAME = 154;
  localparam int DEF_VISIBLE_LINES   = LCD_LINES;
  localparam int DEF_OAM_DOTS        = 80;
  localparam int DEF_XFER_DOTS       = 172;

endpackage

// File: rtl/ppu_stat_irq.sv
// STAT interrupt line: OR of enabled sources, pulsing only on a rising edge of that line.
module ppu_stat_irq
  import video_types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       lyc_match,
  input  logic [3:0] stat_ie,
  input  logic       enable,
  output logic       stat_irq
);

  logic line_d;
  logic line_q;

  always_comb begin
    line_d = (stat_ie[0] && (mode == HBLANK)) ||
             (stat_ie[1] && (mode == VBLANK)) ||
             (stat_ie[2] && (mode == OAM))    ||
             (stat_ie[3] && lyc_match);
  end

  // History tracks the line even while disabled, so re-enabling never sees a stale edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q <= 1'b0;
    end else begin
      line_q <= line_d;
    end
  end

  assign stat_irq = enable && line_d && !line_q;

endmodule

// File: rtl/ppu_timing.sv
// PPU scanline timing: dot/line counters, STAT mode, render and vblank pulses.
// HBLANK | dots after transfer | VBLANK | ly >= visible | OAM | early dots | XFER | pixel transfer
module ppu_timing
  import video_types::*;
#(
  parameter int DOTS_PER_LINE   = DEF_DOTS_PER_LINE,
  parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
  parameter int VISIBLE_LINES   = DEF_VISIBLE_LINES,
  parameter int OAM_DOTS        = DEF_OAM_DOTS,
  parameter int XFER_DOTS       = DEF_XFER_DOTS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dot_en,
  input  logic       lcd_enable,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_ie,
  output logic [7:0] ly,
  output logic [1:0] mode,
  output logic       lyc_match,
  output logic       drawline,
  output logic       vblank_irq,
  output logic       stat_irq
);

  localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] OAM_END   = 9'(OAM_DOTS);
  localparam logic [8:0] XFER_END  = 9'(OAM_DOTS + XFER_DOTS);
  localparam logic [7:0] LINE_LAST = 8'(LINES_PER_FRAME - 1);
  localparam logic [7:0] VIS_FIRST = 8'(VISIBLE_LINES);
  localparam logic [7:0] VIS_LAST  = 8'(VISIBLE_LINES - 1);

  function automatic PpuMode mode_for(input logic [8:0] dot, input logic [7:0] line);
    if (line >= VIS_FIRST) return VBLANK;
    if (dot < OAM_END) return OAM;
    if (dot < XFER_END) return XFER;
    return HBLANK;
  endfunction

  logic [8:0] dot_q, dot_d;
  logic [7:0] ly_q, ly_d;
  PpuMode     mode_q, mode_d;
  logic       drawline_q, drawline_d;
  logic       vblank_q, vblank_d;
  logic       lcd_en_q, lcd_en_d;
  logic       first_q, first_d;
  logic       stat_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dot_q      <= '0;
      ly_q       <= '0;
      mode_q     <= HBLANK;
      drawline_q <= 1'b0;
      vblank_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      dot_q      <= dot_d;
      ly_q       <= ly_d;
      mode_q     <= mode_d;
      drawline_q <= drawline_d;
      vblank_q   <= vblank_d;
      lcd_en_q   <= lcd_en_d;
      first_q    <= first_d;
    end
  end

  always_comb begin
    dot_d      = dot_q;
    ly_d       = ly_q;
    mode_d     = mode_q;
    drawline_d = 1'b0;
    vblank_d   = 1'b0;
    lcd_en_d   = lcd_enable;
    first_d    = 1'b0;
    if (!lcd_enable) begin
      dot_d  = '0;
      ly_d   = '0;
      mode_d = HBLANK;
    end else if (!lcd_en_q) begin
      // LCD just switched on: open a fresh frame without advancing a dot.
      dot_d   = '0;
      ly_d    = '0;
      mode_d  = OAM;
      first_d = 1'b1;
    end else if (dot_en) begin
      if (dot_q == DOT_LAST) begin
        dot_d = '0;
        ly_d  = (ly_q == LINE_LAST) ? 8'd0 : ly_q + 8'd1;
      end else begin
        dot_d = dot_q + 9'd1;
      end
      mode_d     = mode_for(dot_d, ly_d);
      drawline_d = (mode_q == XFER) && (mode_d == HBLANK);
      vblank_d   = (ly_q == VIS_LAST) && (ly_d == VIS_FIRST);
    end
  end

  always_comb begin
    ly         = ly_q;
    mode       = mode_q;
    drawline   = drawline_q;
    vblank_irq = vblank_q;
  end

  assign lyc_match = (ly_q == lyc);
  assign stat_en   = lcd_enable && lcd_en_q && !first_q;

  ppu_stat_irq u_stat_irq (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode_q),
    .lyc_match (lyc_match),
    .stat_ie   (stat_ie),
    .enable    (stat_en),
    .stat_irq  (stat_irq)
  );

endmodule

// File: tb/tb_ppu_timing.sv
// Directed bench for ppu_timing; instance b shares all inputs with a except its reset.
module tb_ppu_timing;

  logic       clk = 1'b0;
  logic       reset, reset_b, dot_en, lcd_enable;
  logic [7:0] lyc;
  logic [3:0] stat_ie;
  logic [7:0] ly_a, ly_b;
  logic [1:0] mode_a, mode_b;
  logic       lm_a, lm_b, dl_a, dl_b, vb_a, vb_b, st_a, st_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ppu_timing dut_a (
    .clk(clk), .reset(reset), .dot_en(dot_en), .lcd_enable(lcd_enable),
    .lyc(lyc), .stat_ie(stat_ie), .ly(ly_a), .mode(mode_a), .lyc_match(lm_a),
    .drawline(dl_a), .vblank_irq(vb_a), .stat_irq(st_a)
  );

  ppu_timing dut_b (
    .clk(clk), .reset(reset_b), .dot_en(dot_en), .lcd_enable(lcd_enable),
    .lyc(lyc), .stat_ie(stat_ie), .ly(ly_b), .mode(mode_b), .lyc_match(lm_b),
    .drawline(dl_b), .vblank_irq(vb_b), .stat_irq(st_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves both instances on the opening cycle of a frame (ly 0, dot 0).
  task automatic restart();
    lcd_enable = 1'b0;
    step();
    lcd_enable = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; reset_b = 1'b1; dot_en = 1'b1; lcd_enable = 1'b1;
    lyc = 8'd0; stat_ie = 4'b1111;
    #1;
    tests++;
    if ({ly_a, mode_a, dl_a, vb_a, st_a} !== 13'd0) begin
      fails++;
      $display("FAIL reset_async: got %h expected 0", {ly_a, mode_a, dl_a, vb_a, st_a});
    end
    step();
    step();
    tests++;
    if ({ly_a, mode_a, dl_a, vb_a, st_a} !== 13'd0) begin
      fails++;
      $display("FAIL reset_held: got %h expected 0", {ly_a, mode_a, dl_a, vb_a, st_a});
    end
    lcd_enable = 1'b0;
    reset = 1'b0; reset_b = 1'b0;
    step();
    tests++;
    if ({ly_a, mode_a, dl_a, vb_a, st_a} !== 13'd0) begin
      fails++;
      $display("FAIL reset_release_off: got %h expected 0", {ly_a, mode_a, dl_a, vb_a, st_a});
    end
  endtask

  task automatic test_frame();
    int dl_cnt = 0, dl_first = -1, dl_bad = 0, vb_cnt = 0, vb_k = -1;
    int s0_cnt = 0, s0_k = -1, lyc_cnt = 0, lyc_k = -1, v_cnt = 0, v_k = -1;
    int b_pulses = 0;
    stat_ie = 4'b0001; lyc = 8'd5; dot_en = 1'b1;
    restart();
    for (int k = 1; k <= 70224; k++) begin
      if (k == 4*456 + 100) stat_ie = 4'b1000;
      if (k == 7*456 + 100) stat_ie = 4'b0011;
      step();
      if (dl_a) begin
        dl_cnt++;
        if (dl_first < 0) dl_first = k;
        if (int'(ly_a) != k / 456) dl_bad++;
      end
      if (vb_a) begin
        vb_cnt++;
        vb_k = k;
      end
      if (st_a) begin
        if (k < 456) begin s0_cnt++; s0_k = k; end
        if (k >= 4*456 && k < 6*456) begin lyc_cnt++; lyc_k = k; end
        if (k >= 143*456 && k < 145*456) begin v_cnt++; v_k = k; end
      end
      if (k >= 45903 && k <= 45960 && (dl_b || vb_b || st_b)) b_pulses++;
      case (k)
        79, 80, 251: begin
          tests++;
          if ({ly_a, mode_a} !== {8'd0, (k == 79) ? 2'd2 : 2'd3}) begin
            fails++;
            $display("FAIL mode_edge_k%0d: got ly %0d mode %0d", k, ly_a, mode_a);
          end
        end
        252: begin
          tests++;
          if ({ly_a, mode_a, dl_a} !== {8'd0, 2'd0, 1'b1}) begin
            fails++;
            $display("FAIL first_drawline: got ly %0d mode %0d dl %0d expected 0 0 1", ly_a, mode_a, dl_a);
          end
        end
        253: begin
          tests++;
          if (dl_a !== 1'b0) begin
            fails++;
            $display("FAIL drawline_width: got %0d expected 0", dl_a);
          end
        end
        456: begin
          tests++;
          if ({ly_a, mode_a, dl_a} !== {8'd1, 2'd2, 1'b0}) begin
            fails++;
            $display("FAIL line_wrap: got ly %0d mode %0d dl %0d expected 1 2 0", ly_a, mode_a, dl_a);
          end
        end
        2735, 2736: begin
          tests++;
          if ({ly_a, lm_a} !== ((k == 2735) ? {8'd5, 1'b1} : {8'd6, 1'b0})) begin
            fails++;
            $display("FAIL lyc_match_k%0d: got ly %0d match %0d", k, ly_a, lm_a);
          end
        end
        2936: begin
          lyc = 8'd6;
          #1;
          tests++;
          if ({st_a, lm_a} !== 2'b11) begin
            fails++;
            $display("FAIL lyc_change_edge: got stat %0d match %0d expected 1 1", st_a, lm_a);
          end
        end
        2937: begin
          tests++;
          if (st_a !== 1'b0) begin
            fails++;
            $display("FAIL lyc_change_once: got %0d expected 0", st_a);
          end
        end
        45900: begin
          tests++;
          if ({ly_b, mode_b} !== {8'd100, 2'd0}) begin
            fails++;
            $display("FAIL b_before_reset: got ly %0d mode %0d expected 100 0", ly_b, mode_b);
          end
          reset_b = 1'b1;
          #1;
          tests++;
          if ({ly_b, mode_b, dl_b, vb_b, st_b} !== 13'd0) begin
            fails++;
            $display("FAIL b_reset_async: got %h expected 0", {ly_b, mode_b, dl_b, vb_b, st_b});
          end
        end
        45901: begin
          tests++;
          if ({ly_b, mode_b, dl_b, vb_b, st_b} !== 13'd0) begin
            fails++;
            $display("FAIL b_reset_held: got %h expected 0", {ly_b, mode_b, dl_b, vb_b, st_b});
          end
          reset_b = 1'b0;
        end
        45902: begin
          tests++;
          if ({ly_b, mode_b, dl_b, vb_b, st_b} !== {8'd0, 2'd2, 3'b000}) begin
            fails++;
            $display("FAIL b_restart: got ly %0d mode %0d pulses %b expected 0 2 000", ly_b, mode_b, {dl_b, vb_b, st_b});
          end
        end
        65663: begin
          tests++;
          if ({ly_a, mode_a} !== {8'd143, 2'd0}) begin
            fails++;
            $display("FAIL last_visible: got ly %0d mode %0d expected 143 0", ly_a, mode_a);
          end
        end
        65664: begin
          // hblank to vblank keeps the STAT line high, so vblank entry is blocked
          tests++;
          if ({ly_a, mode_a, vb_a, st_a} !== {8'd144, 2'd1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL vblank_entry: got ly %0d mode %0d vb %0d st %0d expected 144 1 1 0", ly_a, mode_a, vb_a, st_a);
          end
        end
        65665: begin
          tests++;
          if (vb_a !== 1'b0) begin
            fails++;
            $display("FAIL vblank_width: got %0d expected 0", vb_a);
          end
        end
        70223: begin
          tests++;
          if ({ly_a, mode_a} !== {8'd153, 2'd1}) begin
            fails++;
            $display("FAIL last_line: got ly %0d mode %0d expected 153 1", ly_a, mode_a);
          end
        end
        70224: begin
          tests++;
          if ({ly_a, mode_a, vb_a, st_a} !== {8'd0, 2'd2, 2'b00}) begin
            fails++;
            $display("FAIL frame_wrap: got ly %0d mode %0d vb %0d st %0d expected 0 2 0 0", ly_a, mode_a, vb_a, st_a);
          end
        end
        default: ;
      endcase
    end
    tests++;
    if (dl_cnt != 144 || dl_first != 252 || dl_bad != 0) begin
      fails++;
      $display("FAIL drawline_count: got %0d first %0d badly %0d expected 144 252 0", dl_cnt, dl_first, dl_bad);
    end
    tests++;
    if (vb_cnt != 1 || vb_k != 65664) begin
      fails++;
      $display("FAIL vblank_count: got %0d at %0d expected 1 at 65664", vb_cnt, vb_k);
    end
    tests++;
    if (s0_cnt != 1 || s0_k != 252) begin
      fails++;
      $display("FAIL stat_hblank: got %0d at %0d expected 1 at 252", s0_cnt, s0_k);
    end
    tests++;
    if (lyc_cnt != 1 || lyc_k != 2280) begin
      fails++;
      $display("FAIL stat_lyc: got %0d at %0d expected 1 at 2280", lyc_cnt, lyc_k);
    end
    tests++;
    if (v_cnt != 1 || v_k != 65460) begin
      fails++;
      $display("FAIL stat_143_144: got %0d at %0d expected 1 at 65460", v_cnt, v_k);
    end
    tests++;
    if (b_pulses != 0) begin
      fails++;
      $display("FAIL b_no_pulses: got %0d expected 0", b_pulses);
    end
  endtask

  task automatic test_dot_toggle();
    int m3_j = -1, dl_j = -1, ly1_j = -1, dl_cnt = 0, vb_cnt = 0;
    stat_ie = 4'b0000;
    restart();
    for (int j = 1; j <= 1000; j++) begin
      dot_en = (j % 2 == 0);
      step();
      if (mode_a == 2'd3 && m3_j < 0) m3_j = j;
      if (ly_a == 8'd1 && ly1_j < 0) ly1_j = j;
      if (dl_a) begin
        dl_cnt++;
        if (dl_j < 0) dl_j = j;
      end
      if (vb_a) vb_cnt++;
    end
    tests++;
    if (m3_j != 160 || dl_j != 504 || ly1_j != 912) begin
      fails++;
      $display("FAIL toggle_timing: got m3 %0d dl %0d ly1 %0d expected 160 504 912", m3_j, dl_j, ly1_j);
    end
    tests++;
    if (dl_cnt != 1 || vb_cnt != 0) begin
      fails++;
      $display("FAIL toggle_pulses: got dl %0d vb %0d expected 1 0", dl_cnt, vb_cnt);
    end
  endtask

  task automatic test_lcd_off_on();
    dot_en = 1'b1;
    lcd_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if ({ly_a, mode_a, dl_a, vb_a, st_a} !== 13'd0) begin
        fails++;
        $display("FAIL lcd_off_%0d: got %h expected 0", i, {ly_a, mode_a, dl_a, vb_a, st_a});
      end
    end
    stat_ie = 4'b0100;
    lyc = 8'd0;
    lcd_enable = 1'b1;
    step();
    tests++;
    if ({ly_a, mode_a, lm_a, vb_a, st_a} !== {8'd0, 2'd2, 1'b1, 2'b00}) begin
      fails++;
      $display("FAIL lcd_on_first: got ly %0d mode %0d lm %0d vb %0d st %0d expected 0 2 1 0 0", ly_a, mode_a, lm_a, vb_a, st_a);
    end
    step();
    tests++;
    if ({mode_a, st_a} !== {2'd2, 1'b0}) begin
      fails++;
      $display("FAIL lcd_on_second: got mode %0d st %0d expected 2 0", mode_a, st_a);
    end
    lyc = 8'd3;
    #1;
    tests++;
    if ({lm_a, st_a} !== 2'b00) begin
      fails++;
      $display("FAIL lyc_live: got lm %0d st %0d expected 0 0", lm_a, st_a);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_dot_toggle();
    test_lcd_off_on();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
